// File: rtl/npc_ctrl_fsm.sv
// rtl/npc_ctrl_fsm.sv - multi-cycle fetch/exec/mem/wb sequencer owning pc and instruction register
// Optional NPC_CTRL_PERF_EN adds perf_cycles/perf_instret counters.
module npc_ctrl_fsm #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
    parameter int              WAIT_LIMIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    input  logic            dec_reg_wen,
    input  logic            dec_mem_wen,
    input  logic            dec_mem_ren,
    input  logic            dec_is_ebreak,
    input  logic            dec_inst_not_ipl,
    input  logic [7:0]      dec_wmask,
    input  logic [XLEN-1:0] exu_npc,
    input  logic [XLEN-1:0] exu_mem_addr,
    input  logic [XLEN-1:0] exu_mem_wdata,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wmask,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            rf_wen,
    output logic            commit,
    output logic            halt,
    output logic            trap
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [63:0]     perf_cycles,
    output logic [63:0]     perf_instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_IWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT, S_TRAP
    } state_t;

    // Counter holds cycles already spent in the current wait state; the limit
    // is hit on the WAIT_LIMIT-th cycle, where a handshake still takes priority.
    localparam logic [31:0] WAIT_LAST = (WAIT_LIMIT == 0) ? 32'd0 : 32'(WAIT_LIMIT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] wait_cnt;
    logic        is_wait_state;
    logic        wait_hit;
    logic        npc_misaligned;
    logic        exec_mem;

    assign is_wait_state  = (state == S_FETCH) || (state == S_IWAIT) ||
                            (state == S_MEM)   || (state == S_MWAIT);
    assign wait_hit       = (WAIT_LIMIT != 0) && is_wait_state && (wait_cnt == WAIT_LAST);
    assign npc_misaligned = (exu_npc[1:0] != 2'b00);
    assign exec_mem       = dec_mem_wen | dec_mem_ren;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (imem_req_ready)  state_next = S_IWAIT;
                else if (wait_hit)   state_next = S_TRAP;
            end
            S_IWAIT: begin
                if (imem_rvalid)     state_next = S_EXEC;
                else if (wait_hit)   state_next = S_TRAP;
            end
            S_EXEC: begin
                if (dec_inst_not_ipl)   state_next = S_TRAP;
                else if (dec_is_ebreak) state_next = S_HALT;
                else if (exec_mem)      state_next = S_MEM;
                else                    state_next = S_WB;
            end
            S_MEM: begin
                if (dmem_req_ready)  state_next = S_MWAIT;
                else if (wait_hit)   state_next = S_TRAP;
            end
            S_MWAIT: begin
                if (dmem_rvalid)     state_next = S_WB;
                else if (wait_hit)   state_next = S_TRAP;
            end
            S_WB: begin
                state_next = npc_misaligned ? S_TRAP : S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_FETCH);
        imem_addr      = pc;
        dmem_req_valid = (state == S_MEM);
        commit         = (state == S_WB) && !npc_misaligned;
        rf_wen         = commit && dec_reg_wen;
        halt           = (state == S_HALT);
        trap           = (state == S_TRAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst       <= 32'd0;
            mem_rdata  <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= 8'd0;
            wait_cnt   <= 32'd0;
        end else begin
            if (state_next != state) begin
                wait_cnt <= 32'd0;
            end else if (is_wait_state) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (state == S_IWAIT && imem_rvalid) begin
                inst <= imem_rdata;
            end
            if (state == S_EXEC && !dec_inst_not_ipl && !dec_is_ebreak && exec_mem) begin
                dmem_we    <= dec_mem_wen;
                dmem_addr  <= exu_mem_addr;
                dmem_wdata <= exu_mem_wdata;
                dmem_wmask <= dec_mem_wen ? dec_wmask : 8'd0;
            end
            // Store acks also raise dmem_rvalid; only loads update the writeback data.
            if (state == S_MWAIT && dmem_rvalid && !dmem_we) begin
                mem_rdata <= dmem_rdata;
            end
            if (commit) begin
                pc <= exu_npc;
            end
        end
    end

`ifdef NPC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= 64'd0;
            perf_instret <= 64'd0;
        end else begin
            if (!halt && !trap) begin
                perf_cycles <= perf_cycles + 64'd1;
            end
            if (commit) begin
                perf_instret <= perf_instret + 64'd1;
            end
        end
    end
`endif

endmodule
